// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate-multiplier characterisation library.
// Holds the sequential divider widths, its FSM state type and the
// divide-by-zero saturation values.
package approx_mult_pkg;

    localparam int unsigned DIV_DW = 16;                 // dividend / quotient width
    localparam int unsigned DIV_VW = 8;                  // divisor / remainder width
    localparam int unsigned DIV_PW = DIV_VW + 1;         // partial remainder width
    localparam int unsigned DIV_CW = $clog2(DIV_DW);     // iteration counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [DIV_DW-1:0] DIV_ZERO_QUOT = 16'hFFFF;
    localparam logic [DIV_VW-1:0] DIV_ZERO_REM  = 8'hFF;

endpackage : approx_mult_pkg

// File: rtl/div_step_restoring.sv
// One iteration of restoring division (purely combinational).
// Ports:
//   rem_in   : partial remainder before this step (VW+1 bits)
//   din      : next dividend bit, shifted into the remainder LSB
//   divisor  : unsigned divisor
//   rem_out  : partial remainder after shift and conditional subtract
//   q_bit    : quotient bit produced by this step
module div_step_restoring #(
    parameter int unsigned VW = 8
) (
    input  logic [VW:0]   rem_in,
    input  logic          din,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   rem_out,
    output logic          q_bit
);

    // One bit wider than the remainder so the shift never loses a bit.
    logic [VW+1:0] shifted;
    logic [VW+1:0] divisor_ext;

    assign shifted     = {rem_in, din};
    assign divisor_ext = {2'b00, divisor};
    assign q_bit       = (shifted >= divisor_ext);

    // Result always fits in VW+1 bits once the subtract (if any) is applied.
    assign rem_out = (VW+1)'(q_bit ? (shifted - divisor_ext) : shifted);

endmodule : div_step_restoring

// File: rtl/div_16by8_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : operands presented          in_ready  : operands can be accepted
//   dividend     : unsigned numerator (DW)     divisor   : unsigned denominator (VW)
//   out_valid    : result presented            out_ready : consumer accepts result
//   quotient     : unsigned quotient (DW)      remainder : unsigned remainder (VW)
//   div_by_zero  : result came from a zero divisor (saturated all-ones result)
module div_16by8_seq
    import approx_mult_pkg::*;
#(
    parameter int unsigned DW = DIV_DW,
    parameter int unsigned VW = DIV_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int unsigned CW = $clog2(DW);
    localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

    div_state_t    state;
    div_state_t    state_nxt;

    logic [VW:0]   partial_rem;
    logic [DW-1:0] dividend_shift;
    logic [VW-1:0] divisor_q;
    logic [CW-1:0] count;

    logic [VW:0]   rem_next;
    logic          q_bit;

    logic          accept;
    logic          retire;
    logic          last_iter;

    logic          in_ready_nxt;
    logic          out_valid_nxt;
    logic          load_div;
    logic          load_zero;
    logic          step_en;

    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;
    assign last_iter = (count == LAST_ITER);

    div_step_restoring #(
        .VW (VW)
    ) u_step (
        .rem_in  (partial_rem),
        .din     (dividend_shift[DW-1]),
        .divisor (divisor_q),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (retire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output/control decode; handshake flags are taken from the next state
    // so the registered copies line up with the state register.
    always_comb begin
        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);
        load_div      = 1'b0;
        load_zero     = 1'b0;
        step_en       = 1'b0;
        case (state)
            IDLE: begin
                load_div  = accept && (divisor != '0);
                load_zero = accept && (divisor == '0);
            end
            CALC:    step_en = 1'b1;
            default: ;
        endcase
    end

    // Registered handshake outputs and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            quotient       <= '0;
            remainder      <= '0;
            div_by_zero    <= 1'b0;
            partial_rem    <= '0;
            dividend_shift <= '0;
            divisor_q      <= '0;
            count          <= '0;
        end else begin
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            if (load_div) begin
                dividend_shift <= dividend;
                divisor_q      <= divisor;
                partial_rem    <= '0;
                count          <= '0;
                div_by_zero    <= 1'b0;
            end
            if (load_zero) begin
                quotient    <= DIV_ZERO_QUOT;
                remainder   <= DIV_ZERO_REM;
                div_by_zero <= 1'b1;
            end
            // MSB-first quotient bits enter at the LSB; 16 shifts flush old contents.
            if (step_en) begin
                partial_rem    <= rem_next;
                dividend_shift <= {dividend_shift[DW-2:0], 1'b0};
                quotient       <= {quotient[DW-2:0], q_bit};
                count          <= count + CW'(1);
                if (last_iter) begin
                    remainder <= VW'(rem_next);
                end
            end
        end
    end

endmodule : div_16by8_seq
